// File: rtl/mem_arbiter_pkg.sv
// Shared owner/state encodings for the memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_OAM  = 2'd2,
        OWN_DMC  = 2'd3
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Both DMA sources hold the CPU off the bus while they own it.
    function automatic logic owner_halts_cpu(input owner_t owner);
        return (owner == OWN_OAM) || (owner == OWN_DMC);
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed-priority encoder: DMC over OAM over CPU.
module arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic   cpu_req,
    input  logic   oam_req,
    input  logic   dmc_req,
    output owner_t owner
);

    always_comb begin
        if (dmc_req)      owner = OWN_DMC;
        else if (oam_req) owner = OWN_OAM;
        else if (cpu_req) owner = OWN_CPU;
        else              owner = OWN_NONE;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port among CPU, OAM DMA and DMC fetch, one transaction per CPU tick.
// Optional bus timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_wr,
    output logic          cpu_ack,
    input  logic          oam_req,
    input  logic [AW-1:0] oam_addr,
    input  logic [DW-1:0] oam_wdata,
    input  logic          oam_wr,
    output logic          oam_ack,
    input  logic          dmc_req,
    input  logic [AW-1:0] dmc_addr,
    output logic          dmc_ack,
    output logic [DW-1:0] rdata,
    output logic          cpu_halt,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d, pick;
    logic          mem_req_d, mem_wr_d, finish;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, rdata_d;
    logic          cpu_ack_d, oam_ack_d, dmc_ack_d, halt_d, err_d;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // A requester's level is stale during its own ack cycle, so it is kept out of arbitration.
    arb_prio u_prio (
        .cpu_req (cpu_req & ~cpu_ack),
        .oam_req (oam_req & ~oam_ack),
        .dmc_req (dmc_req & ~dmc_ack),
        .owner   (pick)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wr_d    = mem_wr;
        rdata_d     = rdata;
        cpu_ack_d   = 1'b0;
        oam_ack_d   = 1'b0;
        dmc_ack_d   = 1'b0;
        err_d       = 1'b0;
        finish      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                if (tick && (pick != OWN_NONE)) begin
                    state_d   = ARB_BUSY;
                    owner_d   = pick;
                    mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                    unique case (pick)
                        OWN_DMC: begin
                            mem_addr_d  = dmc_addr;
                            mem_wdata_d = '0;
                            mem_wr_d    = 1'b0;
                        end
                        OWN_OAM: begin
                            mem_addr_d  = oam_addr;
                            mem_wdata_d = oam_wdata;
                            mem_wr_d    = oam_wr;
                        end
                        default: begin
                            mem_addr_d  = cpu_addr;
                            mem_wdata_d = cpu_wdata;
                            mem_wr_d    = cpu_wr;
                        end
                    endcase
                end
            end
            ARB_BUSY: begin
                if (mem_ack) begin
                    finish = 1'b1;
                    if (!mem_wr) rdata_d = mem_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                    if (!mem_wr) rdata_d = '1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                if (finish) begin
                    state_d   = ARB_IDLE;
                    owner_d   = OWN_NONE;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    cpu_ack_d = (owner_q == OWN_CPU);
                    oam_ack_d = (owner_q == OWN_OAM);
                    dmc_ack_d = (owner_q == OWN_DMC);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        halt_d = oam_req | dmc_req | owner_halts_cpu(owner_q);
    end

    // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
    // NOTE: rdata and the mem_* holding registers are reset too, so every output reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            rdata     <= '0;
            cpu_ack   <= 1'b0;
            oam_ack   <= 1'b0;
            dmc_ack   <= 1'b0;
            cpu_halt  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_wr    <= mem_wr_d;
            rdata     <= rdata_d;
            cpu_ack   <= cpu_ack_d;
            oam_ack   <= oam_ack_d;
            dmc_ack   <= dmc_ack_d;
            cpu_halt  <= halt_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'd0;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err   <= err_d;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_d;
    assign err        = 1'b0;
`endif

endmodule
